e203_lsu_icb_arbt: RTL and testbench

- Two-requester ICB arbiter in front of the LSU command/response path.
- Shares one downstream ICB master port between the AGU (requester 0) and the NICE coprocessor (requester 1).
- Tracks outstanding transactions in a source-ID FIFO so that in-order responses return to the requester that issued them.
- Supports NICE memory hold-up and locked (atomic) sequences.

---
 rtl/e203_lsu_pkg.sv | 25 ++
 rtl/e203_lsu_src_fifo.sv | 76 +++++++
 rtl/e203_lsu_icb_arbt.sv | 186 ++++++++++++++++++
 tb/tb_e203_lsu_icb_arbt.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_lsu_pkg.sv
// Shared definitions for the LSU ICB arbiter slice.
// Holds the requester source IDs, the ICB size encodings and the lock-owner
// encoding, plus a helper that maps a source ID to its lock owner.
package e203_lsu_pkg;

  // Requester source IDs, as stored in the outstanding-transaction FIFO
  localparam logic LSU_SRC_AGU  = 1'b0;
  localparam logic LSU_SRC_NICE = 1'b1;

  // ICB cmd_size encodings
  localparam logic [1:0] ICB_SIZE_BYTE = 2'b00;
  localparam logic [1:0] ICB_SIZE_HALF = 2'b01;
  localparam logic [1:0] ICB_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    LockNone,
    LockAgu,
    LockNice
  } lock_own_e;

  function automatic lock_own_e src_to_lock(input logic src);
    return (src == LSU_SRC_NICE) ? LockNice : LockAgu;
  endfunction

endpackage

// File: rtl/e203_lsu_src_fifo.sv
// Source-ID FIFO for outstanding ICB transactions.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, din_i     enqueue one source ID (ignored while full)
//   pop_i, dout_o     dequeue the head ID (ignored while empty)
//   full_o, empty_o   occupancy flags
//   cnt_o             current number of entries
module e203_lsu_src_fifo #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            din_i,
  input  logic            pop_i,
  output logic            dout_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] cnt_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Explicit wrap so a Depth of 1 (pointer range 0..0) also works
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/e203_lsu_icb_arbt.sv
// Two-requester ICB arbiter: AGU (source 0) and NICE (source 1) share one
// downstream ICB port. Commands pass with zero latency; the granted source ID
// is queued so in-order responses are steered back to their issuer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   nice_mem_holdup          give NICE exclusive access (unless a lock is held)
//   agu_icb_cmd_* / rsp_*    AGU ICB requester port
//   nice_icb_cmd_* / rsp_*   NICE ICB requester port
//   o_icb_cmd_* / rsp_*      shared downstream ICB port
//   outs_cnt                 number of outstanding transactions
//   spurious_rsp             pulses the cycle after a response arrives with none outstanding
module e203_lsu_icb_arbt
  import e203_lsu_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned OUTS_DEPTH = 2,
  localparam int unsigned CntW      = $clog2(OUTS_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nice_mem_holdup,

  input  logic            agu_icb_cmd_valid,
  output logic            agu_icb_cmd_ready,
  input  logic [AW-1:0]   agu_icb_cmd_addr,
  input  logic            agu_icb_cmd_read,
  input  logic [DW-1:0]   agu_icb_cmd_wdata,
  input  logic [DW/8-1:0] agu_icb_cmd_wmask,
  input  logic [1:0]      agu_icb_cmd_size,
  input  logic            agu_icb_cmd_lock,
  output logic            agu_icb_rsp_valid,
  input  logic            agu_icb_rsp_ready,
  output logic            agu_icb_rsp_err,
  output logic            agu_icb_rsp_excl_ok,
  output logic [DW-1:0]   agu_icb_rsp_rdata,

  input  logic            nice_icb_cmd_valid,
  output logic            nice_icb_cmd_ready,
  input  logic [AW-1:0]   nice_icb_cmd_addr,
  input  logic            nice_icb_cmd_read,
  input  logic [DW-1:0]   nice_icb_cmd_wdata,
  input  logic [DW/8-1:0] nice_icb_cmd_wmask,
  input  logic [1:0]      nice_icb_cmd_size,
  input  logic            nice_icb_cmd_lock,
  output logic            nice_icb_rsp_valid,
  input  logic            nice_icb_rsp_ready,
  output logic            nice_icb_rsp_err,
  output logic            nice_icb_rsp_excl_ok,
  output logic [DW-1:0]   nice_icb_rsp_rdata,

  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic            o_icb_cmd_read,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  output logic [1:0]      o_icb_cmd_size,
  output logic            o_icb_cmd_lock,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err,
  input  logic            o_icb_rsp_excl_ok,
  input  logic [DW-1:0]   o_icb_rsp_rdata,

  output logic [CntW-1:0] outs_cnt,
  output logic            spurious_rsp
);

  lock_own_e lock_own_q, lock_own_d;
  logic      rr_last_q, rr_last_d;
  logic      spurious_q, spurious_d;

  logic      grant_id;
  logic      grant_valid;
  logic      cmd_hs;
  logic      rsp_hs;
  logic      fifo_full, fifo_empty;
  logic      head_id;
  logic      rsp_to_nice;

  // Grant: lock owner first, then NICE hold-up, then round-robin on ties
  always_comb begin
    grant_id = LSU_SRC_AGU;
    unique case (lock_own_q)
      LockAgu:  grant_id = LSU_SRC_AGU;
      LockNice: grant_id = LSU_SRC_NICE;
      default: begin
        if (nice_mem_holdup) begin
          grant_id = LSU_SRC_NICE;
        end else if (agu_icb_cmd_valid && nice_icb_cmd_valid) begin
          grant_id = ~rr_last_q;
        end else if (nice_icb_cmd_valid) begin
          grant_id = LSU_SRC_NICE;
        end else begin
          grant_id = LSU_SRC_AGU;
        end
      end
    endcase
  end

  assign grant_valid = (grant_id == LSU_SRC_NICE) ? nice_icb_cmd_valid : agu_icb_cmd_valid;

  // No push bypass: a full FIFO blocks commands even if a pop happens this cycle
  assign o_icb_cmd_valid    = grant_valid & ~fifo_full;
  assign agu_icb_cmd_ready  = o_icb_cmd_ready & ~fifo_full & (grant_id == LSU_SRC_AGU);
  assign nice_icb_cmd_ready = o_icb_cmd_ready & ~fifo_full & (grant_id == LSU_SRC_NICE);
  assign cmd_hs             = o_icb_cmd_valid & o_icb_cmd_ready;

  always_comb begin
    if (grant_id == LSU_SRC_NICE) begin
      o_icb_cmd_addr  = nice_icb_cmd_addr;
      o_icb_cmd_read  = nice_icb_cmd_read;
      o_icb_cmd_wdata = nice_icb_cmd_wdata;
      o_icb_cmd_wmask = nice_icb_cmd_wmask;
      o_icb_cmd_size  = nice_icb_cmd_size;
      o_icb_cmd_lock  = nice_icb_cmd_lock;
    end else begin
      o_icb_cmd_addr  = agu_icb_cmd_addr;
      o_icb_cmd_read  = agu_icb_cmd_read;
      o_icb_cmd_wdata = agu_icb_cmd_wdata;
      o_icb_cmd_wmask = agu_icb_cmd_wmask;
      o_icb_cmd_size  = agu_icb_cmd_size;
      o_icb_cmd_lock  = agu_icb_cmd_lock;
    end
  end

  always_comb begin
    lock_own_d = lock_own_q;
    rr_last_d  = rr_last_q;
    if (cmd_hs) begin
      rr_last_d = grant_id;
      // While locked only the owner can handshake, so an unlocked beat releases it
      if (o_icb_cmd_lock) begin
        lock_own_d = src_to_lock(grant_id);
      end else begin
        lock_own_d = LockNone;
      end
    end
  end

  // Response steering by the oldest outstanding source ID
  assign rsp_to_nice          = (head_id == LSU_SRC_NICE);
  assign agu_icb_rsp_valid    = o_icb_rsp_valid & ~fifo_empty & ~rsp_to_nice;
  assign nice_icb_rsp_valid   = o_icb_rsp_valid & ~fifo_empty & rsp_to_nice;
  assign o_icb_rsp_ready      = ~fifo_empty &
                                (rsp_to_nice ? nice_icb_rsp_ready : agu_icb_rsp_ready);
  assign rsp_hs               = o_icb_rsp_valid & o_icb_rsp_ready;

  assign agu_icb_rsp_err      = o_icb_rsp_err;
  assign agu_icb_rsp_excl_ok  = o_icb_rsp_excl_ok;
  assign agu_icb_rsp_rdata    = o_icb_rsp_rdata;
  assign nice_icb_rsp_err     = o_icb_rsp_err;
  assign nice_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
  assign nice_icb_rsp_rdata   = o_icb_rsp_rdata;

  assign spurious_d   = o_icb_rsp_valid & fifo_empty;
  assign spurious_rsp = spurious_q;

  e203_lsu_src_fifo #(
    .Depth (OUTS_DEPTH)
  ) u_src_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_hs),
    .din_i   (grant_id),
    .pop_i   (rsp_hs),
    .dout_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (outs_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_own_q <= LockNone;
      rr_last_q  <= LSU_SRC_NICE;
      spurious_q <= 1'b0;
    end else begin
      lock_own_q <= lock_own_d;
      rr_last_q  <= rr_last_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_e203_lsu_icb_arbt.sv
// Directed table-driven bench for e203_lsu_icb_arbt with OUTS_DEPTH=4.
// Each row drives one cycle of inputs, checks the combinational outputs and
// registered state just before the next rising edge, then lets the edge pass.
module tb_e203_lsu_icb_arbt;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

  localparam logic [AW-1:0]   AGU_ADDR   = 32'h8000_0010;
  localparam logic [DW-1:0]   AGU_WDATA  = 32'h1234_5678;
  localparam logic [3:0]      AGU_WMASK  = 4'hF;
  localparam logic [1:0]      AGU_SIZE   = 2'b10;
  localparam logic [AW-1:0]   NICE_ADDR  = 32'h9000_0020;
  localparam logic [DW-1:0]   NICE_WDATA = 32'h5555_AAAA;
  localparam logic [3:0]      NICE_WMASK = 4'h3;
  localparam logic [1:0]      NICE_SIZE  = 2'b01;

  logic clk = 1'b0;
  logic rst;
  logic nice_mem_holdup;

  logic            agu_icb_cmd_valid, agu_icb_cmd_ready;
  logic [AW-1:0]   agu_icb_cmd_addr;
  logic            agu_icb_cmd_read;
  logic [DW-1:0]   agu_icb_cmd_wdata;
  logic [DW/8-1:0] agu_icb_cmd_wmask;
  logic [1:0]      agu_icb_cmd_size;
  logic            agu_icb_cmd_lock;
  logic            agu_icb_rsp_valid, agu_icb_rsp_ready;
  logic            agu_icb_rsp_err, agu_icb_rsp_excl_ok;
  logic [DW-1:0]   agu_icb_rsp_rdata;

  logic            nice_icb_cmd_valid, nice_icb_cmd_ready;
  logic [AW-1:0]   nice_icb_cmd_addr;
  logic            nice_icb_cmd_read;
  logic [DW-1:0]   nice_icb_cmd_wdata;
  logic [DW/8-1:0] nice_icb_cmd_wmask;
  logic [1:0]      nice_icb_cmd_size;
  logic            nice_icb_cmd_lock;
  logic            nice_icb_rsp_valid, nice_icb_rsp_ready;
  logic            nice_icb_rsp_err, nice_icb_rsp_excl_ok;
  logic [DW-1:0]   nice_icb_rsp_rdata;

  logic            o_icb_cmd_valid, o_icb_cmd_ready;
  logic [AW-1:0]   o_icb_cmd_addr;
  logic            o_icb_cmd_read;
  logic [DW-1:0]   o_icb_cmd_wdata;
  logic [DW/8-1:0] o_icb_cmd_wmask;
  logic [1:0]      o_icb_cmd_size;
  logic            o_icb_cmd_lock;
  logic            o_icb_rsp_valid, o_icb_rsp_ready;
  logic            o_icb_rsp_err, o_icb_rsp_excl_ok;
  logic [DW-1:0]   o_icb_rsp_rdata;

  logic [CNTW-1:0] outs_cnt;
  logic            spurious_rsp;

  int checks = 0;
  int errors = 0;

  // Field order for the positional patterns below:
  // rst hold av al nv nl ordy orv ardy nrdy | chk | acr ncr ocv sel arv nrv orr cnt spur
  typedef struct {
    logic            rst, hold, av, al, nv, nl, ordy, orv, ardy, nrdy;
    logic            chk;
    logic            acr, ncr, ocv, sel, arv, nrv, orr;
    logic [CNTW-1:0] cnt;
    logic            spur;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  e203_lsu_icb_arbt #(
    .AW         (AW),
    .DW         (DW),
    .OUTS_DEPTH (DEPTH)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .nice_mem_holdup      (nice_mem_holdup),
    .agu_icb_cmd_valid    (agu_icb_cmd_valid),
    .agu_icb_cmd_ready    (agu_icb_cmd_ready),
    .agu_icb_cmd_addr     (agu_icb_cmd_addr),
    .agu_icb_cmd_read     (agu_icb_cmd_read),
    .agu_icb_cmd_wdata    (agu_icb_cmd_wdata),
    .agu_icb_cmd_wmask    (agu_icb_cmd_wmask),
    .agu_icb_cmd_size     (agu_icb_cmd_size),
    .agu_icb_cmd_lock     (agu_icb_cmd_lock),
    .agu_icb_rsp_valid    (agu_icb_rsp_valid),
    .agu_icb_rsp_ready    (agu_icb_rsp_ready),
    .agu_icb_rsp_err      (agu_icb_rsp_err),
    .agu_icb_rsp_excl_ok  (agu_icb_rsp_excl_ok),
    .agu_icb_rsp_rdata    (agu_icb_rsp_rdata),
    .nice_icb_cmd_valid   (nice_icb_cmd_valid),
    .nice_icb_cmd_ready   (nice_icb_cmd_ready),
    .nice_icb_cmd_addr    (nice_icb_cmd_addr),
    .nice_icb_cmd_read    (nice_icb_cmd_read),
    .nice_icb_cmd_wdata   (nice_icb_cmd_wdata),
    .nice_icb_cmd_wmask   (nice_icb_cmd_wmask),
    .nice_icb_cmd_size    (nice_icb_cmd_size),
    .nice_icb_cmd_lock    (nice_icb_cmd_lock),
    .nice_icb_rsp_valid   (nice_icb_rsp_valid),
    .nice_icb_rsp_ready   (nice_icb_rsp_ready),
    .nice_icb_rsp_err     (nice_icb_rsp_err),
    .nice_icb_rsp_excl_ok (nice_icb_rsp_excl_ok),
    .nice_icb_rsp_rdata   (nice_icb_rsp_rdata),
    .o_icb_cmd_valid      (o_icb_cmd_valid),
    .o_icb_cmd_ready      (o_icb_cmd_ready),
    .o_icb_cmd_addr       (o_icb_cmd_addr),
    .o_icb_cmd_read       (o_icb_cmd_read),
    .o_icb_cmd_wdata      (o_icb_cmd_wdata),
    .o_icb_cmd_wmask      (o_icb_cmd_wmask),
    .o_icb_cmd_size       (o_icb_cmd_size),
    .o_icb_cmd_lock       (o_icb_cmd_lock),
    .o_icb_rsp_valid      (o_icb_rsp_valid),
    .o_icb_rsp_ready      (o_icb_rsp_ready),
    .o_icb_rsp_err        (o_icb_rsp_err),
    .o_icb_rsp_excl_ok    (o_icb_rsp_excl_ok),
    .o_icb_rsp_rdata      (o_icb_rsp_rdata),
    .outs_cnt             (outs_cnt),
    .spurious_rsp         (spurious_rsp)
  );

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one row, check it 1 time unit later, then wait for the next falling edge
  task automatic apply(input vec_t v, input int idx);
    logic [DW-1:0] rdata;
    logic [7:0]    idx8;
    idx8                = 8'(idx);
    rdata               = 32'hDEAD_BEEF ^ {24'h0, idx8};
    rst                 = v.rst;
    nice_mem_holdup     = v.hold;
    agu_icb_cmd_valid   = v.av;
    agu_icb_cmd_lock    = v.al;
    nice_icb_cmd_valid  = v.nv;
    nice_icb_cmd_lock   = v.nl;
    o_icb_cmd_ready     = v.ordy;
    o_icb_rsp_valid     = v.orv;
    agu_icb_rsp_ready   = v.ardy;
    nice_icb_rsp_ready  = v.nrdy;
    o_icb_rsp_rdata     = rdata;
    o_icb_rsp_err       = idx8[0];
    o_icb_rsp_excl_ok   = idx8[1];
    #1;
    if (v.chk) begin
      check("agu_cmd_ready", idx, 64'(agu_icb_cmd_ready), 64'(v.acr));
      check("nice_cmd_ready", idx, 64'(nice_icb_cmd_ready), 64'(v.ncr));
      check("o_cmd_valid", idx, 64'(o_icb_cmd_valid), 64'(v.ocv));
      check("agu_rsp_valid", idx, 64'(agu_icb_rsp_valid), 64'(v.arv));
      check("nice_rsp_valid", idx, 64'(nice_icb_rsp_valid), 64'(v.nrv));
      check("o_rsp_ready", idx, 64'(o_icb_rsp_ready), 64'(v.orr));
      check("outs_cnt", idx, 64'(outs_cnt), 64'(v.cnt));
      check("spurious_rsp", idx, 64'(spurious_rsp), 64'(v.spur));
      if (v.ocv) begin
        check("o_cmd_addr", idx, 64'(o_icb_cmd_addr), 64'(v.sel ? NICE_ADDR : AGU_ADDR));
        check("o_cmd_wdata", idx, 64'(o_icb_cmd_wdata), 64'(v.sel ? NICE_WDATA : AGU_WDATA));
        check("o_cmd_ctl", idx,
              64'({o_icb_cmd_read, o_icb_cmd_lock, o_icb_cmd_size, o_icb_cmd_wmask}),
              64'(v.sel ? {1'b0, v.nl, NICE_SIZE, NICE_WMASK}
                        : {1'b1, v.al, AGU_SIZE, AGU_WMASK}));
      end
      if (v.arv || v.nrv) begin
        check("agu_rsp_bcast", idx,
              64'({agu_icb_rsp_err, agu_icb_rsp_excl_ok, agu_icb_rsp_rdata}),
              64'({idx8[0], idx8[1], rdata}));
        check("nice_rsp_bcast", idx,
              64'({nice_icb_rsp_err, nice_icb_rsp_excl_ok, nice_icb_rsp_rdata}),
              64'({idx8[0], idx8[1], rdata}));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    agu_icb_cmd_addr   = AGU_ADDR;
    agu_icb_cmd_read   = 1'b1;
    agu_icb_cmd_wdata  = AGU_WDATA;
    agu_icb_cmd_wmask  = AGU_WMASK;
    agu_icb_cmd_size   = AGU_SIZE;
    nice_icb_cmd_addr  = NICE_ADDR;
    nice_icb_cmd_read  = 1'b0;
    nice_icb_cmd_wdata = NICE_WDATA;
    nice_icb_cmd_wmask = NICE_WMASK;
    nice_icb_cmd_size  = NICE_SIZE;

    // Reset state and single AGU read/response
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,0});
    vq.push_back('{0,0,1,0,0,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd0,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,0, 1, 0,0,0,0,1,0,1,3'd1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,0});
    // Round-robin from reset fills the FIFO, fifth command blocked
    vq.push_back('{1,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0,0,3'd0,0});
    vq.push_back('{0,0,1,0,1,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd0,0});
    vq.push_back('{0,0,1,0,1,0,1,0,0,0, 1, 0,1,1,1,0,0,0,3'd1,0});
    vq.push_back('{0,0,1,0,1,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd2,0});
    vq.push_back('{0,0,1,0,1,0,1,0,0,0, 1, 0,1,1,1,0,0,0,3'd3,0});
    vq.push_back('{0,0,1,0,1,0,1,0,0,0, 1, 0,0,0,0,0,0,0,3'd4,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,1,0,1,3'd4,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,0,1,1,3'd3,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,1,0,1,3'd2,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,0,1,1,3'd1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,0});
    // Hold-up: only NICE granted
    vq.push_back('{0,1,1,0,1,0,1,0,0,0, 1, 0,1,1,1,0,0,0,3'd0,0});
    vq.push_back('{0,1,1,0,1,0,1,0,0,0, 1, 0,1,1,1,0,0,0,3'd1,0});
    vq.push_back('{0,1,1,0,1,0,1,0,0,0, 1, 0,1,1,1,0,0,0,3'd2,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,0,1,1,3'd3,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,0,1,1,3'd2,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,0,1,1,3'd1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,0});
    // AGU lock beats NICE hold-up until an unlocked AGU beat
    vq.push_back('{0,0,1,1,0,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd0,0});
    vq.push_back('{0,1,1,1,1,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd1,0});
    vq.push_back('{0,1,1,0,1,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd2,0});
    vq.push_back('{0,1,0,0,1,0,1,0,0,0, 1, 0,1,1,1,0,0,0,3'd3,0});
    // Full with same-cycle pop: no bypass, accepted next cycle
    vq.push_back('{0,0,1,0,0,0,1,1,1,0, 1, 0,0,0,0,1,0,1,3'd4,0});
    vq.push_back('{0,0,1,0,0,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd3,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,1,0,1,3'd4,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,1,0,1,3'd3,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,0,1,1,3'd2,0});
    vq.push_back('{0,0,0,0,0,0,0,1,1,1, 1, 0,0,0,0,1,0,1,3'd1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,0});
    // Downstream not ready: valid shown, requester not ready
    vq.push_back('{0,0,1,0,0,0,0,0,0,0, 1, 0,0,1,0,0,0,0,3'd0,0});
    // Spurious response with nothing outstanding
    vq.push_back('{0,0,0,0,0,0,0,1,1,0, 1, 0,0,0,0,0,0,0,3'd0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,1});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd0,0});

    apply('{1,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0,0,3'd0,0}, 200);
    apply('{1,0,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0,0,3'd0,0}, 201);

    foreach (vq[i]) apply(vq[i], i);

    // Reset in the middle of a locked AGU burst clears FIFO, lock and pointer
    apply('{0,0,1,1,0,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd0,0}, 100);
    apply('{0,0,1,1,0,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd1,0}, 101);
    apply('{1,0,1,1,0,0,1,0,0,0, 1, 1,0,1,0,0,0,0,3'd2,0}, 102);
    apply('{0,1,1,0,1,0,1,1,1,1, 1, 0,1,1,1,0,0,0,3'd0,0}, 103);
    apply('{0,0,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,3'd1,1}, 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
